// File: rtl/st7735_spi_rx_if.sv
// st7735_spi_rx_if: pin and stream bundle for the ST7735 SPI receiver.
//   spi_cs_n/spi_sclk/spi_mosi/spi_dc : 4-wire LCD link (asynchronous to clk)
//   m_data/m_dc/m_valid/m_ready       : received byte stream, valid/ready
//   busy/frame_err/overflow           : receiver status
// master = link driver and stream consumer, slave = the receiver.
interface st7735_spi_rx_if;
    logic       spi_cs_n, spi_sclk, spi_mosi, spi_dc;
    logic [7:0] m_data;
    logic       m_dc, m_valid, m_ready;
    logic       busy, frame_err, overflow;
    modport master (
        output spi_cs_n, spi_sclk, spi_mosi, spi_dc, m_ready,
        input  m_data, m_dc, m_valid, busy, frame_err, overflow
    );
    modport slave (
        input  spi_cs_n, spi_sclk, spi_mosi, spi_dc, m_ready,
        output m_data, m_dc, m_valid, busy, frame_err, overflow
    );
endinterface

// File: rtl/st7735_spi_rx.sv
// st7735_spi_rx: oversampling ST7735 SPI receiver delivering command/data-tagged bytes.
//   clk, rst  : fabric clock, synchronous active-high reset
//   bus.spi_* : asynchronous CS/SCLK/MOSI/DC pins, synchronized internally
//   bus.m_*   : first-word fall-through FIFO output {m_dc, m_data}, pop on m_valid & m_ready
//   bus.busy  : synchronized chip select asserted
//   bus.frame_err : one-cycle pulse when CS releases mid-byte
//   bus.overflow  : sticky, a byte was dropped on a full FIFO
module st7735_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input logic            clk,
    input logic            rst,
    st7735_spi_rx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t                 state;
    logic [SYNC_STAGES:0]   cs_sr, sclk_sr, fill;
    logic [SYNC_STAGES-1:0] mosi_sr, dc_sr;
    logic [2:0]             cnt, cnt_nxt;
    logic [6:0]             sr;
    logic [8:0]             mem [FIFO_DEPTH];
    logic [AW:0]            wp, rp;
    logic                   cs_s, cs_p, mosi_s, dc_s;
    logic                   sclk_rise, cs_fall, cs_rise, push, pop, full, empty;
    assign cs_s      = cs_sr[SYNC_STAGES-1];
    assign cs_p      = cs_sr[SYNC_STAGES];
    assign mosi_s    = mosi_sr[SYNC_STAGES-1];
    assign dc_s      = dc_sr[SYNC_STAGES-1];
    assign sclk_rise = sclk_sr[SYNC_STAGES-1] & ~sclk_sr[SYNC_STAGES];
    // fill marks when the CS edge flop holds a real pin sample rather than its
    // reset value, so a CS already low at reset release never opens a frame.
    assign cs_fall   = state == IDLE && fill[SYNC_STAGES] && cs_p && !cs_s;
    assign cs_rise   = state == SHIFT && !cs_p && cs_s;
    assign push      = state == SHIFT && sclk_rise && cnt == 3'd7;
    assign cnt_nxt   = cnt + {2'b0, sclk_rise};
    assign empty     = wp == rp;
    assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop       = !empty && bus.m_ready;
    assign bus.m_valid = !empty;
    assign {bus.m_dc, bus.m_data} = empty ? 9'd0 : mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sr         <= '1;
            sclk_sr       <= '0;
            mosi_sr       <= '0;
            dc_sr         <= '0;
            fill          <= '0;
            state         <= IDLE;
            cnt           <= '0;
            sr            <= '0;
            bus.busy      <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            cs_sr         <= {cs_sr[SYNC_STAGES-1:0], bus.spi_cs_n};
            sclk_sr       <= {sclk_sr[SYNC_STAGES-1:0], bus.spi_sclk};
            mosi_sr       <= {mosi_sr[SYNC_STAGES-2:0], bus.spi_mosi};
            dc_sr         <= {dc_sr[SYNC_STAGES-2:0], bus.spi_dc};
            fill          <= {fill[SYNC_STAGES-1:0], 1'b1};
            bus.frame_err <= 1'b0;
            if (cs_fall) begin
                // an SCLK edge coincident with CS falling is bit 1 of the new byte
                state    <= SHIFT;
                bus.busy <= 1'b1;
                cnt      <= {2'b0, sclk_rise};
                sr       <= {6'd0, sclk_rise & mosi_s};
            end else if (state == SHIFT) begin
                if (sclk_rise) begin
                    cnt <= cnt_nxt;
                    sr  <= {sr[5:0], mosi_s};
                end
                if (cs_rise) begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.frame_err <= cnt_nxt != 3'd0;
                end
            end
        end
    end
    // The 8th bit goes straight from the synchronizer into the FIFO entry;
    // writing a full FIFO is legal when the head slot is popped in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp           <= '0;
            rp           <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (push && (!full || pop)) begin
                mem[wp[AW-1:0]] <= {dc_s, sr, mosi_s};
                wp              <= wp + (AW+1)'(1);
            end
            if (pop)
                rp <= rp + (AW+1)'(1);
            if (push && full && !pop)
                bus.overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_st7735_spi_rx.sv
// tb_st7735_spi_rx: directed and randomized bench for st7735_spi_rx against a byte-queue model.
module tb_st7735_spi_rx;
    localparam int SS = 2;
    localparam int FD = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    st7735_spi_rx_if bus ();
    st7735_spi_rx #(.SYNC_STAGES(SS), .FIFO_DEPTH(FD)) dut (.clk(clk), .rst(rst), .bus(bus));
    int         checks = 0, errors = 0;
    int         fe_cnt = 0, stall_viol = 0, occ = 0, fe0;
    bit         stalled = 0, exp_ovf = 0;
    logic [8:0] exp_q[$], got_q[$];
    logic [8:0] last_head = '0;
    logic       last_stall = 1'b0;
    logic [7:0] rb;
    // consumer side: record every handshake, frame_err high cycles and head stability under stall
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) got_q.push_back({bus.m_dc, bus.m_data});
        if (!rst && bus.frame_err) fe_cnt <= fe_cnt + 1;
        if (!rst && last_stall && {bus.m_dc, bus.m_data} !== last_head) stall_viol <= stall_viol + 1;
        last_stall <= !rst && bus.m_valid && !bus.m_ready;
        last_head  <= {bus.m_dc, bus.m_data};
    end
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    // MSB-first bits with randomized SCLK phases; late_ready raises m_ready so the
    // consumer's first pop lands on the same clock as the detected 8th edge.
    task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits, input bit late_ready);
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.spi_dc   = dc;
            bus.spi_mosi = b[i];
            wait_clk(int'($urandom_range(6, 4)));
            bus.spi_sclk = 1'b1;
            if (late_ready && i == 0) begin
                wait_clk(2);
                bus.m_ready = 1'b1;
                wait_clk(2);
            end else
                wait_clk(int'($urandom_range(6, 4)));
            bus.spi_sclk = 1'b0;
        end
    endtask
    task automatic model_byte(input logic [7:0] b, input logic dc);
        if (!stalled || occ < FD) begin
            exp_q.push_back({dc, b});
            if (stalled) occ++;
        end else
            exp_ovf = 1'b1;
    endtask
    task automatic send_byte(input logic [7:0] b, input logic dc);
        send_bits(b, dc, 8, 1'b0);
        model_byte(b, dc);
    endtask
    task automatic frame_begin();
        bus.spi_cs_n = 1'b0;
        wait_clk(4);
    endtask
    task automatic frame_end();
        wait_clk(4);
        bus.spi_cs_n = 1'b1;
        wait_clk(8);
    endtask
    task automatic compare_q(input string tag);
        wait_clk(10);
        chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_item%0d", tag, i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask
    initial begin
        rst          = 1'b1;
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_dc   = 1'b0;
        bus.m_ready  = 1'b1;
        wait_clk(4);
        chk("rst_m_data", {24'd0, bus.m_data}, 32'd0);
        chk("rst_m_dc", {31'd0, bus.m_dc}, 32'd0);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        rst = 1'b0;
        wait_clk(10);
        fe0 = fe_cnt;
        frame_begin();
        chk("t1_busy_in_frame", {31'd0, bus.busy}, 32'd1);
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h7F, 1'b1);
        frame_end();
        chk("t1_busy_after", {31'd0, bus.busy}, 32'd0);
        compare_q("t1");
        chk("t1_frame_err", fe_cnt - fe0, 32'd0);
        chk("t1_overflow", {31'd0, bus.overflow}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            frame_begin();
            for (int j = 0; j < int'($urandom_range(4, 1)); j++) begin
                rb = 8'($urandom);
                send_byte(rb, 1'($urandom));
            end
            frame_end();
        end
        compare_q("rand");
        fe0 = fe_cnt;
        frame_begin();
        send_bits(8'hA5, 1'b1, 5, 1'b0);
        frame_end();
        chk("ferr_pulse", fe_cnt - fe0, 32'd1);
        frame_begin();
        send_byte(8'h3C, 1'b1);
        frame_end();
        chk("ferr_clean_frame", fe_cnt - fe0, 32'd1);
        compare_q("ferr");
        for (int k = 0; k < 8; k++) begin
            bus.spi_sclk = 1'b1;
            wait_clk(4);
            bus.spi_sclk = 1'b0;
            wait_clk(4);
        end
        chk("idle_sclk_busy", {31'd0, bus.busy}, 32'd0);
        compare_q("idle_sclk");
        bus.m_ready = 1'b0;
        stalled     = 1'b1;
        occ         = 0;
        frame_begin();
        for (int v = 1; v <= FD; v++) send_byte(8'(8'h10 + v), 1'b0);
        chk("full_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("full_head", {23'd0, bus.m_dc, bus.m_data}, {23'd0, exp_q[0]});
        stalled = 1'b0;
        occ     = 0;
        send_bits(8'h99, 1'b1, 8, 1'b1);
        model_byte(8'h99, 1'b1);
        frame_end();
        compare_q("full_pop");
        chk("full_pop_overflow", {31'd0, bus.overflow}, 32'd0);
        bus.m_ready = 1'b0;
        stalled     = 1'b1;
        occ         = 0;
        frame_begin();
        for (int v = 1; v <= FD + 1; v++) send_byte(8'(v), 1'b1);
        frame_end();
        chk("ovf_set", {31'd0, bus.overflow}, {31'd0, exp_ovf});
        chk("ovf_head", {24'd0, bus.m_data}, 32'h01);
        bus.m_ready = 1'b1;
        stalled     = 1'b0;
        compare_q("ovf");
        chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
        fe0 = fe_cnt;
        frame_begin();
        send_bits(8'hFF, 1'b1, 4, 1'b0);
        wait_clk(2);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(10);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_overflow", {31'd0, bus.overflow}, 32'd0);
        chk("rst_mid_valid", {31'd0, bus.m_valid}, 32'd0);
        bus.spi_cs_n = 1'b1;
        wait_clk(8);
        frame_begin();
        send_byte(8'h55, 1'b0);
        frame_end();
        compare_q("rst_mid");
        chk("rst_mid_frame_err", fe_cnt - fe0, 32'd0);
        chk("stall_stability", stall_viol, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
